beta_alu_issue: RTL and testbench

//  Operate-class issue/retire stage that sits in front of the Beta ALU. Accepts one 32-bit Beta

---
 rtl/beta_alu_issue.sv | 153 +++++++++++++++
 tb/tb_beta_alu_issue.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/beta_alu_issue.sv
// Operate-class issue/retire stage for the Beta ALU: decodes one instruction, reads the
// 31-entry register file, drives the ALU for one cycle, then writes Rc back and retires.
module beta_alu_issue #(
    parameter int DWIDTH = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       in_instr,
    output logic              in_ready,
    output logic [5:0]        alu_opcode,
    output logic [DWIDTH-1:0] alu_a,
    output logic [DWIDTH-1:0] alu_b,
    input  logic [DWIDTH-1:0] alu_result,
    output logic              retire_valid,
    output logic [4:0]        retire_rc,
    output logic [DWIDTH-1:0] retire_data,
    output logic              illegal,
    output logic              div_zero,
    input  logic [4:0]        dbg_addr,
    output logic [DWIDTH-1:0] dbg_data
);

    typedef enum logic {S_IDLE, S_EXEC} state_t;

    localparam logic [4:0] RZ     = 5'(NREGS - 1);
    localparam logic [5:0] OP_DIV = 6'h23;

    state_t state_q, state_d;

    logic [DWIDTH-1:0] rf_q [NREGS-1];
    logic [DWIDTH-1:0] rf_d [NREGS-1];

    logic [5:0]        alu_opcode_q, alu_opcode_d;
    logic [DWIDTH-1:0] alu_a_q, alu_a_d;
    logic [DWIDTH-1:0] alu_b_q, alu_b_d;
    logic [4:0]        rc_q, rc_d;
    logic              retire_valid_q, retire_valid_d;
    logic [4:0]        retire_rc_q, retire_rc_d;
    logic [DWIDTH-1:0] retire_data_q, retire_data_d;
    logic              illegal_q, illegal_d;
    logic              div_zero_q, div_zero_d;

    logic [5:0]        op;
    logic [4:0]        rc, ra, rb;
    logic [15:0]       lit;
    logic              legal, accept, dz, wr_en;
    logic [DWIDTH-1:0] ra_val, rb_val;

    assign op  = in_instr[31:26];
    assign rc  = in_instr[25:21];
    assign ra  = in_instr[20:16];
    assign rb  = in_instr[15:11];
    assign lit = in_instr[15:0];

    // Legal ops are 0x20-0x3F minus every xx111 slot (0x27, 0x2F, 0x37, 0x3F).
    assign legal  = op[5] && (op[2:0] != 3'b111);
    assign accept = in_ready && in_valid;

    assign ra_val   = (ra == RZ) ? '0 : rf_q[ra];
    assign rb_val   = (rb == RZ) ? '0 : rf_q[rb];
    assign dbg_data = (dbg_addr == RZ) ? '0 : rf_q[dbg_addr];

    assign dz    = (alu_opcode_q == OP_DIV) && (alu_b_q == '0);
    assign wr_en = (rc_q != RZ) && !dz;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && legal) state_d = S_EXEC;
            S_EXEC:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Reset gates in_ready so nothing is accepted while the stage is being cleared.
    always_comb begin
        in_ready = (state_q == S_IDLE) && !reset;
    end

    always_comb begin
        rf_d           = rf_q;
        alu_opcode_d   = alu_opcode_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        rc_d           = rc_q;
        retire_valid_d = 1'b0;
        retire_rc_d    = retire_rc_q;
        retire_data_d  = retire_data_q;
        illegal_d      = 1'b0;
        div_zero_d     = 1'b0;
        if (state_q == S_IDLE && accept) begin
            if (legal) begin
                // Constant forms issue as their register-form opcode.
                alu_opcode_d = op & 6'h2F;
                alu_a_d      = ra_val;
                alu_b_d      = op[4] ? {{(DWIDTH-16){lit[15]}}, lit} : rb_val;
                rc_d         = rc;
            end else begin
                illegal_d = 1'b1;
            end
        end
        if (state_q == S_EXEC) begin
            retire_valid_d = 1'b1;
            retire_rc_d    = rc_q;
            div_zero_d     = dz;
            retire_data_d  = wr_en ? alu_result : '0;
            if (wr_en) rf_d[rc_q] = alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS - 1; i++) rf_q[i] <= '0;
            alu_opcode_q   <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            rc_q           <= '0;
            retire_valid_q <= 1'b0;
            retire_rc_q    <= '0;
            retire_data_q  <= '0;
            illegal_q      <= 1'b0;
            div_zero_q     <= 1'b0;
        end else begin
            rf_q           <= rf_d;
            alu_opcode_q   <= alu_opcode_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            rc_q           <= rc_d;
            retire_valid_q <= retire_valid_d;
            retire_rc_q    <= retire_rc_d;
            retire_data_q  <= retire_data_d;
            illegal_q      <= illegal_d;
            div_zero_q     <= div_zero_d;
        end
    end

    assign alu_opcode   = alu_opcode_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign retire_valid = retire_valid_q;
    assign retire_rc    = retire_rc_q;
    assign retire_data  = retire_data_q;
    assign illegal      = illegal_q;
    assign div_zero     = div_zero_q;

endmodule

// File: tb/tb_beta_alu_issue.sv
// Directed bench for beta_alu_issue with a small behavioural ALU on the alu_* interface.
module tb_beta_alu_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic [5:0]  alu_opcode;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        retire_valid;
    logic [4:0]  retire_rc;
    logic [31:0] retire_data;
    logic        illegal, div_zero;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_total = 0;
    int n_bad   = 0;

    beta_alu_issue #(.DWIDTH(32), .NREGS(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .retire_valid(retire_valid), .retire_rc(retire_rc),
        .retire_data(retire_data), .illegal(illegal), .div_zero(div_zero),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Reference ALU: only the operations this bench issues.
    always_comb begin
        alu_result = 32'h0;
        case (alu_opcode)
            6'h20: alu_result = alu_a + alu_b;
            6'h21: alu_result = alu_a - alu_b;
            6'h23: alu_result = (alu_b == 32'h0) ? 32'h0 : 32'($signed(alu_a) / $signed(alu_b));
            default: alu_result = 32'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", {31'h0, in_ready}, 32'h1);
    endtask

    task automatic dbg(input logic [4:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        chk($sformatf("dbg_r%0d", a), dbg_data, exp);
    endtask

    task automatic issue_legal(input logic [31:0] instr, input logic [5:0] exp_op,
                               input logic [31:0] exp_b, input logic [4:0] exp_rc,
                               input logic [31:0] exp_data, input logic exp_dz);
        wait_ready();
        in_valid = 1'b1;
        in_instr = instr;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("exec_ready", {31'h0, in_ready}, 32'h0);
        chk("exec_rv", {31'h0, retire_valid}, 32'h0);
        chk("exec_op", {26'h0, alu_opcode}, {26'h0, exp_op});
        chk("exec_b", alu_b, exp_b);
        @(posedge clk); #1;
        chk("ret_valid", {31'h0, retire_valid}, 32'h1);
        chk("ret_rc", {27'h0, retire_rc}, {27'h0, exp_rc});
        chk("ret_data", retire_data, exp_data);
        chk("ret_dz", {31'h0, div_zero}, {31'h0, exp_dz});
        chk("ret_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;
        chk("pulse_rv", {31'h0, retire_valid}, 32'h0);
        chk("pulse_dz", {31'h0, div_zero}, 32'h0);
    endtask

    task automatic issue_illegal(input logic [31:0] instr);
        wait_ready();
        in_valid = 1'b1;
        in_instr = instr;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("ill_pulse", {31'h0, illegal}, 32'h1);
        chk("ill_rv", {31'h0, retire_valid}, 32'h0);
        chk("ill_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;
        chk("ill_end", {31'h0, illegal}, 32'h0);
        chk("ill_rv2", {31'h0, retire_valid}, 32'h0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_instr = 32'h0;
        dbg_addr = 5'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, in_ready}, 32'h0);
        chk("rst_rv", {31'h0, retire_valid}, 32'h0);
        chk("rst_op", {26'h0, alu_opcode}, 32'h0);
        chk("rst_a", alu_a, 32'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", {31'h0, in_ready}, 32'h1);
        for (int i = 0; i < 32; i++) dbg(5'(i), 32'h0);

        // ADDC R1=R31+5, ADDC R2=R31-3, SUB R3=R1-R2 (dependent back-to-back)
        issue_legal(32'hC03F0005, 6'h20, 32'h00000005, 5'd1, 32'h00000005, 1'b0);
        issue_legal(32'hC05FFFFD, 6'h20, 32'hFFFFFFFD, 5'd2, 32'hFFFFFFFD, 1'b0);
        issue_legal(32'h84611000, 6'h21, 32'hFFFFFFFD, 5'd3, 32'h00000008, 1'b0);
        dbg(5'd1, 32'h00000005);
        dbg(5'd2, 32'hFFFFFFFD);
        dbg(5'd3, 32'h00000008);

        // Illegal opcodes 0x27 and 0x00 targeting R6
        issue_illegal(32'h9CC10000);
        issue_illegal(32'h00C10000);
        dbg(5'd6, 32'h0);
        dbg(5'd1, 32'h00000005);

        // DIV by zero, then DIVC R4=R1/1
        issue_legal(32'h8C81F800, 6'h23, 32'h00000000, 5'd4, 32'h00000000, 1'b1);
        dbg(5'd4, 32'h0);
        issue_legal(32'hCC810001, 6'h23, 32'h00000001, 5'd4, 32'h00000005, 1'b0);
        dbg(5'd4, 32'h00000005);

        // Write to R31 is discarded
        issue_legal(32'hC3FF0007, 6'h20, 32'h00000007, 5'd31, 32'h00000000, 1'b0);
        dbg(5'd31, 32'h0);

        // Reset during EXEC of ADDC R5=R31+9
        wait_ready();
        in_valid = 1'b1;
        in_instr = 32'hC0BF0009;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_exec_ready", {31'h0, in_ready}, 32'h0);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", {31'h0, in_ready}, 32'h0);
        @(posedge clk); #1;
        chk("mid_rst_rv", {31'h0, retire_valid}, 32'h0);
        reset = 1'b0;
        #1;
        chk("mid_rst_idle", {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;
        chk("mid_rst_rv2", {31'h0, retire_valid}, 32'h0);
        chk("mid_rst_ready2", {31'h0, in_ready}, 32'h1);
        dbg(5'd5, 32'h0);
        dbg(5'd1, 32'h0);

        // Stage still works after the aborted instruction
        issue_legal(32'hC0BF0009, 6'h20, 32'h00000009, 5'd5, 32'h00000009, 1'b0);
        dbg(5'd5, 32'h00000009);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
